// File: rtl/sme_host_driver.sv
// rtl/sme_host_driver.sv - host-side string/pattern transmitter for the string-matching engine
module sme_host_driver #(
    parameter int STR_MAX     = 32,
    parameter int PAT_MAX     = 8,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_wr_en,
    input  logic       i_wr_sel,
    input  logic [7:0] i_wr_data,
    input  logic       i_clr,
    input  logic       i_start,
    input  logic       i_skip_string,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_result_match,
    output logic [4:0] o_result_index,
    output logic       o_timeout,
    output logic       o_ovf,
    output logic [7:0] o_chardata,
    output logic       o_isstring,
    output logic       o_ispattern,
    input  logic       i_valid,
    input  logic       i_match,
    input  logic [4:0] i_match_index
);

    localparam int MAXLEN = (STR_MAX > PAT_MAX) ? STR_MAX : PAT_MAX;
    localparam int LW     = $clog2(MAXLEN + 1);
    localparam int SW     = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
    localparam int PW     = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
    localparam int CW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [LW-1:0] STR_FULL = LW'(STR_MAX);
    localparam logic [LW-1:0] PAT_FULL = LW'(PAT_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND_STR, S_SEND_PAT, S_WAIT} state_t;

    state_t        r_state;
    logic [LW-1:0] r_str_len, r_pat_len, r_idx;
    logic [CW-1:0] r_cnt;
    logic          r_str_sent;
    logic          r_busy, r_done, r_result_match, r_timeout, r_ovf;
    logic [4:0]    r_result_index;
    logic [7:0]    r_chardata;
    logic          r_isstring, r_ispattern;
    logic [7:0]    r_str_mem [STR_MAX];
    logic [7:0]    r_pat_mem [PAT_MAX];

    logic       w_idle, w_skip, w_start_ok, w_wr, w_str_we, w_pat_we;
    logic [7:0] w_str_rd, w_pat_rd;

    assign w_idle     = (r_state == S_IDLE);
    assign w_skip     = i_skip_string && r_str_sent;
    assign w_start_ok = w_idle && i_start && (r_pat_len != '0) && ((r_str_len != '0) || w_skip);
    // A start accepted this cycle wins over clr/writes so the lengths it launched with stay intact.
    assign w_wr       = w_idle && i_wr_en && !i_clr && !w_start_ok;
    assign w_str_we   = w_wr && !i_wr_sel && (r_str_len != STR_FULL);
    assign w_pat_we   = w_wr && i_wr_sel && (r_pat_len != PAT_FULL);
    assign w_str_rd   = r_str_mem[r_idx[SW-1:0]];
    assign w_pat_rd   = r_pat_mem[r_idx[PW-1:0]];

    always_ff @(posedge clk) begin
        if (w_str_we) r_str_mem[r_str_len[SW-1:0]] <= i_wr_data;
        if (w_pat_we) r_pat_mem[r_pat_len[PW-1:0]] <= i_wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_str_len      <= '0;
            r_pat_len      <= '0;
            r_idx          <= '0;
            r_cnt          <= '0;
            r_str_sent     <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_result_match <= 1'b0;
            r_result_index <= '0;
            r_timeout      <= 1'b0;
            r_ovf          <= 1'b0;
            r_chardata     <= '0;
            r_isstring     <= 1'b0;
            r_ispattern    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_busy <= 1'b1;
                        r_idx  <= LW'(1);
                        if (w_skip) begin
                            r_state     <= S_SEND_PAT;
                            r_chardata  <= r_pat_mem[0];
                            r_ispattern <= 1'b1;
                        end else begin
                            r_state    <= S_SEND_STR;
                            r_chardata <= r_str_mem[0];
                            r_isstring <= 1'b1;
                        end
                    end else if (i_clr) begin
                        r_str_len <= '0;
                        r_pat_len <= '0;
                        r_ovf     <= 1'b0;
                    end else if (i_wr_en) begin
                        if (!i_wr_sel) begin
                            if (w_str_we) r_str_len <= r_str_len + LW'(1);
                            else          r_ovf     <= 1'b1;
                        end else begin
                            if (w_pat_we) r_pat_len <= r_pat_len + LW'(1);
                            else          r_ovf     <= 1'b1;
                        end
                    end
                end
                S_SEND_STR: begin
                    if (r_idx != r_str_len) begin
                        r_chardata <= w_str_rd;
                        r_idx      <= r_idx + LW'(1);
                    end else begin
                        r_state     <= S_SEND_PAT;
                        r_str_sent  <= 1'b1;
                        r_chardata  <= r_pat_mem[0];
                        r_isstring  <= 1'b0;
                        r_ispattern <= 1'b1;
                        r_idx       <= LW'(1);
                    end
                end
                S_SEND_PAT: begin
                    if (r_idx != r_pat_len) begin
                        r_chardata <= w_pat_rd;
                        r_idx      <= r_idx + LW'(1);
                    end else begin
                        // The first quiet cycle on the stream is what triggers the engine.
                        r_state     <= S_WAIT;
                        r_chardata  <= '0;
                        r_ispattern <= 1'b0;
                        r_idx       <= '0;
                        r_cnt       <= '0;
                    end
                end
                S_WAIT: begin
                    if (i_valid) begin
                        r_state        <= S_IDLE;
                        r_busy         <= 1'b0;
                        r_done         <= 1'b1;
                        r_result_match <= i_match;
                        r_result_index <= i_match_index;
                        r_timeout      <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state        <= S_IDLE;
                        r_busy         <= 1'b0;
                        r_done         <= 1'b1;
                        r_result_match <= 1'b0;
                        r_result_index <= '0;
                        r_timeout      <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_result_match = r_result_match;
    assign o_result_index = r_result_index;
    assign o_timeout      = r_timeout;
    assign o_ovf          = r_ovf;
    assign o_chardata     = r_chardata;
    assign o_isstring     = r_isstring;
    assign o_ispattern    = r_ispattern;

endmodule

// File: tb/tb_sme_host_driver.sv
// tb/tb_sme_host_driver.sv - self-checking bench for sme_host_driver
module tb_sme_host_driver;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_wr_en, i_wr_sel, i_clr, i_start, i_skip_string;
    logic [7:0] i_wr_data;
    logic       i_valid, i_match;
    logic [4:0] i_match_index;
    logic       o_busy, o_done, o_result_match, o_timeout, o_ovf, o_isstring, o_ispattern;
    logic [4:0] o_result_index;
    logic [7:0] o_chardata;

    always #5 clk = ~clk;

    sme_host_driver #(.STR_MAX(32), .PAT_MAX(8), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset),
        .i_wr_en(i_wr_en), .i_wr_sel(i_wr_sel), .i_wr_data(i_wr_data),
        .i_clr(i_clr), .i_start(i_start), .i_skip_string(i_skip_string),
        .o_busy(o_busy), .o_done(o_done),
        .o_result_match(o_result_match), .o_result_index(o_result_index),
        .o_timeout(o_timeout), .o_ovf(o_ovf),
        .o_chardata(o_chardata), .o_isstring(o_isstring), .o_ispattern(o_ispattern),
        .i_valid(i_valid), .i_match(i_match), .i_match_index(i_match_index)
    );

    typedef struct packed {
        logic       busy;
        logic       isstr;
        logic       ispat;
        logic       done;
        logic [7:0] ch;
        logic       rmatch;
        logic [4:0] ridx;
        logic       rto;
    } ent_t;

    // Model state: buffer contents, sticky flags, result registers, expected per-cycle timeline.
    byte        m_str[$];
    byte        m_pat[$];
    bit         m_sent;
    logic       m_ovf, m_rmatch, m_rto;
    logic [4:0] m_ridx;
    ent_t       exq[$];
    ent_t       e;

    int  checks = 0, failures = 0;
    int  cyc = 0, done_cnt = 0, done_cyc = 0, last_pat_cyc = 0, first_pat_cyc = -1, start_cyc = 0;
    bit  cmp_en = 1'b0;
    byte seen_str[$];
    byte seen_pat[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always begin
        @(posedge clk);
        #3;
        cyc++;
        if (cmp_en) begin
            e = (exq.size() != 0) ? exq.pop_front() : '0;
            if (e.done) begin
                m_rmatch = e.rmatch;
                m_ridx   = e.ridx;
                m_rto    = e.rto;
            end
            chk("stream", 32'({o_busy, o_isstring, o_ispattern, o_done, o_chardata}),
                32'({e.busy, e.isstr, e.ispat, e.done, e.ch}));
            chk("result", 32'({o_result_match, o_result_index, o_timeout, o_ovf}),
                32'({m_rmatch, m_ridx, m_rto, m_ovf}));
            if (o_isstring) seen_str.push_back(byte'(o_chardata));
            if (o_ispattern) begin
                seen_pat.push_back(byte'(o_chardata));
                last_pat_cyc = cyc;
                if (first_pat_cyc < 0) first_pat_cyc = cyc;
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_logs();
        seen_str.delete();
        seen_pat.delete();
        first_pat_cyc = -1;
    endtask

    task automatic model_reset();
        exq.delete();
        m_str.delete();
        m_pat.delete();
        m_sent = 1'b0; m_ovf = 1'b0;
        m_rmatch = 1'b0; m_ridx = '0; m_rto = 1'b0;
    endtask

    task automatic wr1(input bit sel, input byte ch);
        @(negedge clk);
        i_wr_en = 1'b1; i_wr_sel = sel; i_wr_data = ch;
        if (!sel) begin
            if (m_str.size() < 32) m_str.push_back(ch); else m_ovf = 1'b1;
        end else begin
            if (m_pat.size() < 8) m_pat.push_back(ch); else m_ovf = 1'b1;
        end
    endtask

    task automatic wr_str(input bit sel, input string s);
        for (int i = 0; i < s.len(); i++) wr1(sel, s[i]);
        @(negedge clk);
        i_wr_en = 1'b0;
    endtask

    task automatic wr_rep(input bit sel, input int n, input byte base);
        for (int i = 0; i < n; i++) wr1(sel, byte'(base + i));
        @(negedge clk);
        i_wr_en = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk);
        i_clr = 1'b1;
        m_str.delete(); m_pat.delete(); m_ovf = 1'b0;
        @(negedge clk);
        i_clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // d >= 0: valid in WAIT cycle d (0-based); d < 0: engine silent. rst_pat > 0: reset during that pattern char.
    task automatic txn(input bit skip, input int d, input bit mt, input logic [4:0] ix,
                       input bit noise, input bit poke, input int rst_pat);
        int   L, P, W;
        bit   hon;
        ent_t t;
        @(negedge clk);
        i_start = 1'b1; i_skip_string = skip;
        start_cyc = cyc;
        hon = skip && m_sent;
        if (m_pat.size() == 0 || (m_str.size() == 0 && !hon)) begin
            @(negedge clk);
            i_start = 1'b0; i_skip_string = 1'b0;
            return;
        end
        L = hon ? 0 : m_str.size();
        P = m_pat.size();
        W = (d >= 0) ? d + 1 : TO;
        for (int k = 0; k < L; k++) begin
            t = '0; t.busy = 1'b1; t.isstr = 1'b1; t.ch = m_str[k]; exq.push_back(t);
        end
        for (int k = 0; k < P; k++) begin
            t = '0; t.busy = 1'b1; t.ispat = 1'b1; t.ch = m_pat[k]; exq.push_back(t);
        end
        for (int k = 0; k < W; k++) begin
            t = '0; t.busy = 1'b1; exq.push_back(t);
        end
        t = '0; t.done = 1'b1;
        t.rmatch = (d >= 0) ? mt : 1'b0;
        t.ridx   = (d >= 0) ? ix : 5'd0;
        t.rto    = (d < 0);
        exq.push_back(t);
        for (int k = 1; k <= L + P + W; k++) begin
            @(negedge clk);
            i_start = 1'b0; i_skip_string = 1'b0;
            if (rst_pat > 0 && k == L + rst_pat) begin
                reset = 1'b1;
                model_reset();
                #1;
                chk("rst_async", 32'({o_busy, o_isstring, o_ispattern, o_done}), 32'd0);
                chk("rst_chardata", 32'(o_chardata), 32'd0);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            i_valid = (d >= 0 && k == L + P + 1 + d);
            i_match = mt; i_match_index = ix;
            if (noise && k <= L + P) begin
                i_valid = 1'b1; i_match = ~mt; i_match_index = ~ix;
            end
            if (poke && k == 2) begin
                i_wr_en = 1'b1; i_wr_sel = 1'b1; i_wr_data = "Z"; i_start = 1'b1; i_clr = 1'b1;
            end else begin
                i_wr_en = 1'b0; i_clr = 1'b0;
            end
        end
        @(negedge clk);
        i_valid = 1'b0; i_match = 1'b0; i_match_index = '0;
        if (L > 0) m_sent = 1'b1;
    endtask

    int dc;

    initial begin
        reset = 1'b1;
        i_wr_en = 0; i_wr_sel = 0; i_wr_data = 0; i_clr = 0; i_start = 0; i_skip_string = 0;
        i_valid = 0; i_match = 0; i_match_index = 0;
        model_reset();
        #1;
        chk("reset_ctrl", 32'({o_busy, o_done, o_timeout, o_ovf, o_result_match}), 32'd0);
        chk("reset_stream", 32'({o_isstring, o_ispattern, o_chardata, o_result_index}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cmp_en = 1'b1;

        // Basic transaction with garbage on valid during the send phases.
        wr_str(0, "ab cd");
        wr_str(1, "cd");
        clear_logs();
        txn(0, 1, 1, 5'd3, 1, 0, 0);
        chk("t1_str_len", 32'(seen_str.size()), 32'd5);
        chk("t1_str0", 32'(seen_str[0]), 32'h61);
        chk("t1_str2", 32'(seen_str[2]), 32'h20);
        chk("t1_str4", 32'(seen_str[4]), 32'h64);
        chk("t1_pat_len", 32'(seen_pat.size()), 32'd2);
        chk("t1_done_lat", 32'(done_cyc - last_pat_cyc), 32'd3);
        chk("t1_result", 32'({o_result_match, o_result_index, o_busy}), 32'({1'b1, 5'd3, 1'b0}));

        // Honoured skip: pattern goes out immediately after start.
        do_clr();
        wr_str(0, "ab cd");
        wr_str(1, "^c");
        clear_logs();
        txn(1, 0, 0, 5'd7, 0, 0, 0);
        chk("t2_no_str", 32'(seen_str.size()), 32'd0);
        chk("t2_pat0", 32'(seen_pat[0]), 32'h5e);
        chk("t2_first_pat", 32'(first_pat_cyc - start_cyc), 32'd1);

        // Skip requested on first transaction after reset: string still sent.
        do_reset();
        wr_str(0, "xyz");
        wr_str(1, "y");
        clear_logs();
        txn(1, 2, 1, 5'd21, 0, 0, 0);
        chk("t3_str_sent", 32'(seen_str.size()), 32'd3);
        chk("t3_idx", 32'(o_result_index), 32'd21);

        // Full buffers and overflow.
        do_clr();
        wr_rep(0, 33, "A");
        chk("t4_ovf_str", 32'(o_ovf), 32'd1);
        wr_rep(1, 9, "0");
        clear_logs();
        txn(0, 2, 1, 5'd31, 0, 0, 0);
        chk("t4_str_full", 32'(seen_str.size()), 32'd32);
        chk("t4_str31", 32'(seen_str[31]), 32'h60);
        chk("t4_pat_full", 32'(seen_pat.size()), 32'd8);
        do_clr();
        chk("t4_ovf_clr", 32'(o_ovf), 32'd0);
        wr_str(0, "a");
        dc = done_cnt;
        txn(0, 0, 1, 5'd1, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("t4_ign_done", 32'(done_cnt), 32'(dc));
        chk("t4_ign_busy", 32'(o_busy), 32'd0);

        // Timeout.
        wr_str(1, "q");
        clear_logs();
        txn(0, -1, 1, 5'd9, 0, 0, 0);
        chk("t5_to_lat", 32'(done_cyc - last_pat_cyc), 32'd17);
        chk("t5_result", 32'({o_timeout, o_result_match, o_result_index}), 32'({1'b1, 1'b0, 5'd0}));

        // Writes, clr and start while busy are ignored.
        txn(1, 3, 1, 5'd5, 0, 1, 0);
        clear_logs();
        txn(1, 0, 0, 5'd2, 0, 0, 0);
        chk("t6_pat_keep", 32'(seen_pat.size()), 32'd1);
        chk("t6_pat0", 32'(seen_pat[0]), 32'h71);
        chk("t6_timeout_clr", 32'(o_timeout), 32'd0);

        // Reset during pattern send.
        wr_str(1, "rs");
        dc = done_cnt;
        txn(0, 5, 1, 5'd1, 0, 0, 2);
        repeat (2) @(negedge clk);
        chk("t7_no_done", 32'(done_cnt), 32'(dc));
        wr_str(0, "hi");
        wr_str(1, "i");
        clear_logs();
        txn(1, 0, 1, 5'd1, 0, 0, 0);
        chk("t7_str_resent", 32'(seen_str.size()), 32'd2);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
